// File: rtl/iob_cache_line_fill.sv
//==============================================================================
// Module   : iob_cache_line_fill
// Brief    : Cache line-fill engine. Requests a line from the read channel,
//            writes each returned beat to data memory, then commits tag/valid.
//            The optional critical-word forward is enabled by IOB_CACHE_FILL_FWD_EN.
// Revision : 1.0 - initial release
//==============================================================================
`ifndef IOB_CACHE_ADDR_W
`define IOB_CACHE_ADDR_W 32
`endif
`ifndef IOB_CACHE_DATA_W
`define IOB_CACHE_DATA_W 32
`endif
`ifndef IOB_CACHE_BE_DATA_W
`define IOB_CACHE_BE_DATA_W 64
`endif
`ifndef IOB_CACHE_WORD_OFFSET_W
`define IOB_CACHE_WORD_OFFSET_W 3
`endif

`default_nettype none

module iob_cache_line_fill #(
    parameter int  FE_ADDR_W     = `IOB_CACHE_ADDR_W,
    parameter int  FE_DATA_W     = `IOB_CACHE_DATA_W,
    parameter int  BE_DATA_W     = `IOB_CACHE_BE_DATA_W,
    parameter int  WORD_OFFSET_W = `IOB_CACHE_WORD_OFFSET_W,
    localparam int BE_NBYTES_W   = $clog2(BE_DATA_W / 8),
    localparam int FE2BE_W       = $clog2(BE_DATA_W / FE_DATA_W),
    localparam int LINE2BE_W     = WORD_OFFSET_W - FE2BE_W,
    localparam int AW            = (LINE2BE_W > 0) ? LINE2BE_W : 1,
    localparam int LA            = FE_ADDR_W - BE_NBYTES_W - LINE2BE_W
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     miss_i,
    input  logic [LA-1:0]            miss_addr_i,
    input  logic [WORD_OFFSET_W-1:0] miss_word_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     tag_we_o,
    output logic                     err_o,
    output logic                     replace_valid_o,
    output logic [LA-1:0]            replace_addr_o,
    input  logic                     replace_i,
    input  logic                     read_valid_i,
    input  logic [AW-1:0]            read_addr_i,
    input  logic [BE_DATA_W-1:0]     read_rdata_i,
    output logic                     data_we_o,
    output logic [AW-1:0]            data_addr_o,
    output logic [BE_DATA_W-1:0]     data_wdata_o,
    output logic                     fwd_valid_o,
    output logic [FE_DATA_W-1:0]     fwd_data_o
);

    localparam int               CNT_W    = LINE2BE_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(2 ** LINE2BE_W);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        FILL   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [LA-1:0]            addr_q, addr_d;
    logic [WORD_OFFSET_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic                     w_beat;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        word_d          = word_q;
        cnt_d           = cnt_q;
        err_d           = err_q;
        w_beat          = 1'b0;
        replace_valid_o = 1'b0;
        tag_we_o        = 1'b0;
        done_o          = 1'b0;

        // A beat outside FILL, or beyond a full line, is a protocol violation.
        if (read_valid_i && ((state_q != FILL) || (cnt_q == CNT_FULL)))
            err_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (miss_i) begin
                    addr_d  = miss_addr_i;
                    word_d  = miss_word_i;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                replace_valid_o = 1'b1;
                state_d         = FILL;
            end
            FILL: begin
                w_beat = read_valid_i && (cnt_q != CNT_FULL);
                if (w_beat)
                    cnt_d = cnt_q + CNT_W'(1);
                // Uses the post-beat count so a final beat coinciding with
                // replace_i falling still commits on the next cycle.
                if ((cnt_d == CNT_FULL) && !replace_i)
                    state_d = COMMIT;
            end
            COMMIT: begin
                tag_we_o = 1'b1;
                done_o   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o         = (state_q != IDLE);
    assign err_o          = err_q;
    assign replace_addr_o = addr_q;
    assign data_we_o      = w_beat;
    assign data_wdata_o   = w_beat ? read_rdata_i : '0;

    generate
        if (LINE2BE_W > 0) begin : g_multi_beat
            assign data_addr_o = w_beat ? read_addr_i : '0;
        end else begin : g_single_beat
            logic w_unused_addr;
            assign w_unused_addr = ^read_addr_i;
            assign data_addr_o   = '0;
        end
    endgenerate

`ifdef IOB_CACHE_FILL_FWD_EN
    logic                 fwd_valid_q;
    logic [FE_DATA_W-1:0] fwd_data_q;
    logic                 w_fwd_hit;
    logic [FE_DATA_W-1:0] w_fwd_word;

    generate
        if (LINE2BE_W > 0) begin : g_fwd_hit_idx
            assign w_fwd_hit = (read_addr_i == word_q[WORD_OFFSET_W-1:FE2BE_W]);
        end else begin : g_fwd_hit_one
            assign w_fwd_hit = 1'b1;
        end
        if (FE2BE_W > 0) begin : g_fwd_sel
            assign w_fwd_word = FE_DATA_W'(read_rdata_i >> (word_q[FE2BE_W-1:0] * FE_DATA_W));
        end else begin : g_fwd_whole
            assign w_fwd_word = FE_DATA_W'(read_rdata_i);
        end
    endgenerate

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            fwd_valid_q <= w_beat && w_fwd_hit;
            if (w_beat && w_fwd_hit)
                fwd_data_q <= w_fwd_word;
        end
    end

    assign fwd_valid_o = fwd_valid_q;
    assign fwd_data_o  = fwd_data_q;
`else
    logic w_unused_word;
    assign w_unused_word = ^word_q;
    assign fwd_valid_o   = 1'b0;
    assign fwd_data_o    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_iob_cache_line_fill.sv
//==============================================================================
// Module   : tb_iob_cache_line_fill
// Brief    : Scoreboard bench for iob_cache_line_fill (32-bit FE, 64-bit BE,
//            4 beats per line).
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_iob_cache_line_fill;

    localparam int FE_ADDR_W     = 32;
    localparam int FE_DATA_W     = 32;
    localparam int BE_DATA_W     = 64;
    localparam int WORD_OFFSET_W = 3;
    localparam int AW            = 2;
    localparam int LA            = 27;

    logic                     clk_i = 1'b0;
    logic                     reset_i;
    logic                     miss_i;
    logic [LA-1:0]            miss_addr_i;
    logic [WORD_OFFSET_W-1:0] miss_word_i;
    logic                     busy_o, done_o, tag_we_o, err_o;
    logic                     replace_valid_o;
    logic [LA-1:0]            replace_addr_o;
    logic                     replace_i;
    logic                     read_valid_i;
    logic [AW-1:0]            read_addr_i;
    logic [BE_DATA_W-1:0]     read_rdata_i;
    logic                     data_we_o;
    logic [AW-1:0]            data_addr_o;
    logic [BE_DATA_W-1:0]     data_wdata_o;
    logic                     fwd_valid_o;
    logic [FE_DATA_W-1:0]     fwd_data_o;

    iob_cache_line_fill #(
        .FE_ADDR_W(FE_ADDR_W), .FE_DATA_W(FE_DATA_W),
        .BE_DATA_W(BE_DATA_W), .WORD_OFFSET_W(WORD_OFFSET_W)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .miss_i(miss_i), .miss_addr_i(miss_addr_i), .miss_word_i(miss_word_i),
        .busy_o(busy_o), .done_o(done_o), .tag_we_o(tag_we_o), .err_o(err_o),
        .replace_valid_o(replace_valid_o), .replace_addr_o(replace_addr_o),
        .replace_i(replace_i),
        .read_valid_i(read_valid_i), .read_addr_i(read_addr_i), .read_rdata_i(read_rdata_i),
        .data_we_o(data_we_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .fwd_valid_o(fwd_valid_o), .fwd_data_o(fwd_data_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;
    int done_seen = 0;
    int rv_seen   = 0;

    logic [AW+BE_DATA_W-1:0] exp_wr[$];
    logic [FE_DATA_W-1:0]    exp_fwd[$];
    logic [AW+BE_DATA_W-1:0] mon_wr;
    logic [FE_DATA_W-1:0]    mon_fwd;
    logic [BE_DATA_W-1:0]    bd[4];

    // Scoreboard: pops expected data-memory writes and forwards as they appear.
    always @(negedge clk_i) begin
        if (done_o) done_seen++;
        if (replace_valid_o) rv_seen++;
        if (done_o || tag_we_o) begin
            checks++;
            if (tag_we_o !== done_o) begin
                failures++;
                $display("FAIL tag_done_pair got tag=%b done=%b required equal", tag_we_o, done_o);
            end
        end
        if (data_we_o) begin
            checks++;
            if (exp_wr.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got addr=%0d data=%h required none", data_addr_o, data_wdata_o);
            end else begin
                mon_wr = exp_wr.pop_front();
                if ({data_addr_o, data_wdata_o} !== mon_wr) begin
                    failures++;
                    $display("FAIL data_write got %h required %h", {data_addr_o, data_wdata_o}, mon_wr);
                end
            end
`ifndef IOB_CACHE_FILL_FWD_EN
            checks++;
            if (fwd_valid_o !== 1'b0 || fwd_data_o !== '0) begin
                failures++;
                $display("FAIL fwd_disabled got v=%b d=%h required 0", fwd_valid_o, fwd_data_o);
            end
`endif
        end
`ifdef IOB_CACHE_FILL_FWD_EN
        if (fwd_valid_o) begin
            checks++;
            if (exp_fwd.size() == 0) begin
                failures++;
                $display("FAIL unexpected_fwd got %h required none", fwd_data_o);
            end else begin
                mon_fwd = exp_fwd.pop_front();
                if (fwd_data_o !== mon_fwd) begin
                    failures++;
                    $display("FAIL fwd_data got %h required %h", fwd_data_o, mon_fwd);
                end
            end
        end
`endif
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset_i = 1'b1; miss_i = 1'b0; miss_addr_i = '0; miss_word_i = '0;
        replace_i = 1'b0; read_valid_i = 1'b0; read_addr_i = '0; read_rdata_i = '0;
        repeat (2) @(posedge clk_i);
        #1 reset_i = 1'b0;
    endtask

    task automatic check_queues(input string name);
        checks++;
        if (exp_wr.size() != 0 || exp_fwd.size() != 0) begin
            failures++;
            $display("FAIL %s_queues got wr=%0d fwd=%0d required 0", name, exp_wr.size(), exp_fwd.size());
        end
        exp_wr.delete();
        exp_fwd.delete();
    endtask

    task automatic run_fill(input logic [LA-1:0] a, input logic [2:0] w,
                            input bit mid_miss, input bit drop_on_last);
        miss_i = 1'b1; miss_addr_i = a; miss_word_i = w;
        @(posedge clk_i); #1;
        miss_i = 1'b0; miss_addr_i = '0;
        checks++;
        if (replace_valid_o !== 1'b1 || replace_addr_o !== a || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL req got rv=%b addr=%h busy=%b required 1/%h/1", replace_valid_o, replace_addr_o, busy_o, a);
        end
        @(posedge clk_i); #1;
        checks++;
        if (replace_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL rv_one_cycle got %b required 0", replace_valid_o);
        end
        replace_i = 1'b1;
        for (int b = 0; b < 4; b++) begin
            read_valid_i = 1'b1; read_addr_i = 2'(b); read_rdata_i = bd[b];
            exp_wr.push_back({2'(b), bd[b]});
            if (int'(w[2:1]) == b)
                exp_fwd.push_back(w[0] ? bd[b][63:32] : bd[b][31:0]);
            if (mid_miss && b == 1) begin
                miss_i = 1'b1; miss_addr_i = ~a; miss_word_i = ~w;
            end
            if (drop_on_last && b == 3) replace_i = 1'b0;
            @(posedge clk_i); #1;
            miss_i = 1'b0; miss_addr_i = '0;
        end
        read_valid_i = 1'b0;
`ifndef IOB_CACHE_FILL_FWD_EN
        exp_fwd.delete();
`endif
        if (!drop_on_last) begin
            checks++;
            if (done_o !== 1'b0 || busy_o !== 1'b1) begin
                failures++;
                $display("FAIL commit_waits got done=%b busy=%b required 0/1", done_o, busy_o);
            end
            replace_i = 1'b0;
            @(posedge clk_i); #1;
        end
        checks++;
        if (done_o !== 1'b1 || tag_we_o !== 1'b1 || replace_addr_o !== a) begin
            failures++;
            $display("FAIL commit got done=%b tag=%b addr=%h required 1/1/%h", done_o, tag_we_o, replace_addr_o, a);
        end
        @(posedge clk_i); #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || tag_we_o !== 1'b0) begin
            failures++;
            $display("FAIL back_idle got busy=%b done=%b tag=%b required 0", busy_o, done_o, tag_we_o);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({busy_o, done_o, tag_we_o, err_o, replace_valid_o, data_we_o, fwd_valid_o} !== 7'b0 ||
            replace_addr_o !== '0 || data_addr_o !== '0 || data_wdata_o !== '0 || fwd_data_o !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b err=%b rv=%b addr=%h required all 0",
                     busy_o, done_o, err_o, replace_valid_o, replace_addr_o);
        end
    endtask

    task automatic test_basic();
        int d0, r0;
        d0 = done_seen; r0 = rv_seen;
        for (int b = 0; b < 4; b++) bd[b] = {32'hCAFE0000 + 32'(b), 32'h000000A0 + 32'(b)};
        run_fill(27'h1234, 3'd0, 1'b0, 1'b0);
        checks++;
        if (done_seen - d0 != 1 || rv_seen - r0 != 1) begin
            failures++;
            $display("FAIL basic_counts got done=%0d rv=%0d required 1/1", done_seen - d0, rv_seen - r0);
        end
        check_queues("basic");
    endtask

    task automatic test_fwd();
        for (int b = 0; b < 4; b++) bd[b] = {32'h5A5A0000 + 32'(b), 32'h000000A0 + 32'(b)};
        bd[2] = 64'h11112222_33334444;
        run_fill(27'h0ABC, 3'd5, 1'b0, 1'b0);
        @(posedge clk_i); #1;
`ifdef IOB_CACHE_FILL_FWD_EN
        checks++;
        if (fwd_valid_o !== 1'b0 || fwd_data_o !== 32'h11112222) begin
            failures++;
            $display("FAIL fwd_hold got v=%b d=%h required 0/11112222", fwd_valid_o, fwd_data_o);
        end
`endif
        check_queues("fwd");
    endtask

    task automatic test_mid_miss();
        int d0;
        d0 = done_seen;
        for (int b = 0; b < 4; b++) bd[b] = {32'h0BADF00D ^ 32'(b), 32'h000000A0 + 32'(b)};
        run_fill(27'h2468, 3'd2, 1'b1, 1'b0);
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (done_seen - d0 != 1 || busy_o !== 1'b0 || replace_addr_o !== 27'h2468) begin
            failures++;
            $display("FAIL mid_miss got done=%0d busy=%b addr=%h required 1/0/2468", done_seen - d0, busy_o, replace_addr_o);
        end
        check_queues("mid_miss");
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_seen;
        for (int b = 0; b < 4; b++) bd[b] = {32'h12340000 + 32'(b), 32'hB00000A0 + 32'(b)};
        run_fill(27'h7FFFFFF, 3'd7, 1'b0, 1'b1);
        for (int b = 0; b < 4; b++) bd[b] = {32'h9ABC0000 + 32'(b), 32'hC00000A0 + 32'(b)};
        run_fill(27'h0000001, 3'd1, 1'b0, 1'b1);
        checks++;
        if (done_seen - d0 != 2) begin
            failures++;
            $display("FAIL back_to_back got done=%0d required 2", done_seen - d0);
        end
        check_queues("b2b");
    endtask

    task automatic test_reset_mid_fill();
        int d0;
        d0 = done_seen;
        miss_i = 1'b1; miss_addr_i = 27'h55; miss_word_i = 3'd0;
        @(posedge clk_i); #1 miss_i = 1'b0;
        @(posedge clk_i); #1 replace_i = 1'b1;
        for (int b = 0; b < 2; b++) begin
            read_valid_i = 1'b1; read_addr_i = 2'(b); read_rdata_i = 64'hDEAD0000_000000A0 + 64'(b);
            exp_wr.push_back({2'(b), 64'hDEAD0000_000000A0 + 64'(b)});
            @(posedge clk_i); #1;
        end
        read_valid_i = 1'b0;
        reset_i = 1'b1;
        #1;
        checks++;
        if ({busy_o, done_o, tag_we_o, replace_valid_o, data_we_o, fwd_valid_o} !== 6'b0 || replace_addr_o !== '0) begin
            failures++;
            $display("FAIL async_reset got busy=%b done=%b tag=%b addr=%h required 0", busy_o, done_o, tag_we_o, replace_addr_o);
        end
        replace_i = 1'b0;
        @(posedge clk_i); #1 reset_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (done_seen != d0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL partial_no_done got done=%0d busy=%b required 0/0", done_seen - d0, busy_o);
        end
        exp_fwd.delete();
        check_queues("reset_pre");
        for (int b = 0; b < 4; b++) bd[b] = {32'h77770000 + 32'(b), 32'h000000A0 + 32'(b)};
        run_fill(27'h77, 3'd3, 1'b0, 1'b0);
        checks++;
        if (done_seen - d0 != 1) begin
            failures++;
            $display("FAIL after_reset_fill got done=%0d required 1", done_seen - d0);
        end
        check_queues("reset_post");
    endtask

    task automatic test_err_idle();
        checks++;
        if (err_o !== 1'b0) begin
            failures++;
            $display("FAIL err_clean got %b required 0", err_o);
        end
        read_valid_i = 1'b1; read_addr_i = 2'd1; read_rdata_i = 64'hFFFF;
        #1;
        checks++;
        if (data_we_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_write got %b required 0", data_we_o);
        end
        @(posedge clk_i); #1 read_valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        checks++;
        if (err_o !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky got %b required 1", err_o);
        end
        do_reset();
        checks++;
        if (err_o !== 1'b0) begin
            failures++;
            $display("FAIL err_reset got %b required 0", err_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fwd();
        test_mid_miss();
        test_back_to_back();
        test_reset_mid_fill();
        test_err_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
